// File: rtl/pipelined_control_path.sv
// Decode-stage control generator for the RV32I core and the control pipeline that
// carries it through ID/EX, MEM_LAT memory stages and WB with valid, stall and flush.
package pipelined_control_path_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_ctl;
    logic       alu_src;
    logic       branch;
    logic       jmp;
    logic       jalr;
    logic [2:0] f3;
    logic       is_load;
    logic       illegal;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
  } ex_ctl_t;

  // Control still needed after the first memory stage
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctl_t;

endpackage

module pipelined_control_path
  import pipelined_control_path_pkg::*;
#(
  parameter int unsigned ALU_CTL_W = 4,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_f3,
  input  logic                 i_f7_b6,
  input  logic                 i_valid_d,
  input  logic                 i_stall_e,
  input  logic                 i_flush_e,
  output logic [2:0]           o_imm_src,
  output logic                 o_ex_valid,
  output logic [ALU_CTL_W-1:0] o_ex_alu_ctl,
  output logic                 o_ex_alu_src,
  output logic                 o_ex_branch,
  output logic                 o_ex_jmp,
  output logic                 o_ex_jalr,
  output logic [2:0]           o_ex_f3,
  output logic                 o_ex_is_load,
  output logic                 o_ex_illegal,
  output logic                 o_mem_valid,
  output logic                 o_mem_write,
  output logic                 o_mem_reg_write,
  output logic                 o_wb_valid,
  output logic                 o_wb_reg_write,
  output logic [1:0]           o_wb_result_src
);

  localparam int unsigned N_STG = MEM_LAT + 1;

  ex_ctl_t dec;
  ex_ctl_t ex_q;
  wb_ctl_t ex_to_mem;
  wb_ctl_t stg_q [N_STG];
  logic    mem_write_q;

  // Shared R/I ALU mapping; only R-type may turn f3=000 into SUB
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7_b6,
                                        input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && f7_b6) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7_b6 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // Instruction decode in ID
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.f3      = i_f3;
    o_imm_src   = IMM_I;
    case (i_opcode)
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.is_load    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        o_imm_src     = IMM_S;
      end
      OP_R: begin
        dec.alu_ctl   = alu_of(i_f3, i_f7_b6, 1'b1);
        dec.reg_write = 1'b1;
      end
      OP_I: begin
        dec.alu_ctl   = alu_of(i_f3, i_f7_b6, 1'b0);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BR: begin
        dec.alu_ctl = ALU_SUB;
        dec.branch  = 1'b1;
        o_imm_src   = IMM_B;
      end
      OP_JAL: begin
        dec.jmp        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        o_imm_src      = IMM_J;
      end
      OP_JALR: begin
        dec.alu_src    = 1'b1;
        dec.jmp        = 1'b1;
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_IMM;
        o_imm_src      = IMM_U;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    ex_to_mem            = '0;
    ex_to_mem.valid      = ex_q.valid;
    ex_to_mem.reg_write  = ex_q.reg_write;
    ex_to_mem.result_src = ex_q.result_src;
  end

  // Flush beats stall; either one sends a bubble into the first memory stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      mem_write_q <= 1'b0;
      for (int unsigned i = 0; i < N_STG; i++) stg_q[i] <= '0;
    end else begin
      if (i_flush_e)      ex_q <= '0;
      else if (!i_stall_e) ex_q <= i_valid_d ? dec : '0;
      if (i_flush_e || i_stall_e) begin
        stg_q[0]    <= '0;
        mem_write_q <= 1'b0;
      end else begin
        stg_q[0]    <= ex_to_mem;
        mem_write_q <= ex_q.mem_write;
      end
      for (int unsigned i = 1; i < N_STG; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign o_ex_valid      = ex_q.valid;
  assign o_ex_alu_ctl    = ALU_CTL_W'(ex_q.alu_ctl);
  assign o_ex_alu_src    = ex_q.alu_src;
  assign o_ex_branch     = ex_q.branch;
  assign o_ex_jmp        = ex_q.jmp;
  assign o_ex_jalr       = ex_q.jalr;
  assign o_ex_f3         = ex_q.f3;
  assign o_ex_is_load    = ex_q.is_load;
  assign o_ex_illegal    = ex_q.illegal;
  assign o_mem_valid     = stg_q[0].valid;
  assign o_mem_write     = mem_write_q;
  assign o_mem_reg_write = stg_q[0].reg_write;
  assign o_wb_valid      = stg_q[N_STG-1].valid;
  assign o_wb_reg_write  = stg_q[N_STG-1].reg_write;
  assign o_wb_result_src = stg_q[N_STG-1].result_src;

endmodule

// File: tb/tb_pipelined_control_path.sv
// Randomized bench for pipelined_control_path (MEM_LAT=3) against an instruction-level
// reference model: a decode table plus a delay line of in-flight instructions.
module tb_pipelined_control_path;

  localparam int unsigned AW = 5;
  localparam int unsigned ML = 3;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, BAD = 7'b1111111;

  logic          clk, rst_n;
  logic [6:0]    opcode;
  logic [2:0]    f3;
  logic          f7_b6, valid_d, stall_e, flush_e;
  logic [2:0]    imm_src;
  logic          ex_valid, ex_alu_src, ex_branch, ex_jmp, ex_jalr, ex_is_load, ex_illegal;
  logic [AW-1:0] ex_alu_ctl;
  logic [2:0]    ex_f3;
  logic          mem_valid, mem_write, mem_reg_write, wb_valid, wb_reg_write;
  logic [1:0]    wb_result_src;

  pipelined_control_path #(.ALU_CTL_W(AW), .MEM_LAT(ML)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_f3(f3), .i_f7_b6(f7_b6),
    .i_valid_d(valid_d), .i_stall_e(stall_e), .i_flush_e(flush_e),
    .o_imm_src(imm_src), .o_ex_valid(ex_valid), .o_ex_alu_ctl(ex_alu_ctl),
    .o_ex_alu_src(ex_alu_src), .o_ex_branch(ex_branch), .o_ex_jmp(ex_jmp),
    .o_ex_jalr(ex_jalr), .o_ex_f3(ex_f3), .o_ex_is_load(ex_is_load),
    .o_ex_illegal(ex_illegal), .o_mem_valid(mem_valid), .o_mem_write(mem_write),
    .o_mem_reg_write(mem_reg_write), .o_wb_valid(wb_valid),
    .o_wb_reg_write(wb_reg_write), .o_wb_result_src(wb_result_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [3:0] alu; logic asrc, br, jmp, jalr; logic [2:0] f3;
    logic ld, ill, mw, rw; logic [1:0] res;
  } ins_t;

  ins_t ex_m;
  ins_t line_m [ML+1];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: instruction class -> control fields
  function automatic ins_t ref_dec(input logic [6:0] op, input logic [2:0] fn3,
                                   input logic b30);
    int   op_tbl [8] = '{0, 6, 5, 9, 4, 7, 3, 2};
    ins_t r = '0;
    int   arith = op_tbl[fn3];
    if (fn3 == 3'd5 && b30) arith = 8;
    r.v = 1'b1; r.f3 = fn3;
    if (op == LW)        begin r.asrc = 1; r.ld = 1; r.rw = 1; r.res = 2'd1; end
    else if (op == SW)   begin r.asrc = 1; r.mw = 1; end
    else if (op == RT)   begin r.alu = 4'((fn3 == 0 && b30) ? 1 : arith); r.rw = 1; end
    else if (op == IT)   begin r.alu = 4'(arith); r.asrc = 1; r.rw = 1; end
    else if (op == BR)   begin r.alu = 4'd1; r.br = 1; end
    else if (op == JAL)  begin r.jmp = 1; r.rw = 1; r.res = 2'd2; end
    else if (op == JALR) begin r.asrc = 1; r.jmp = 1; r.jalr = 1; r.rw = 1; r.res = 2'd2; end
    else if (op == LUI)  begin r.rw = 1; r.res = 2'd3; end
    else                 r.ill = 1;
    return r;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    if (op == SW)  return 3'd1;
    if (op == BR)  return 3'd2;
    if (op == JAL) return 3'd3;
    if (op == LUI) return 3'd4;
    return 3'd0;
  endfunction

  task automatic model_reset();
    ex_m = '0;
    for (int i = 0; i <= ML; i++) line_m[i] = '0;
  endtask

  // One clock edge of the instruction flow
  task automatic model_edge();
    ins_t into_mem;
    if (!rst_n) begin
      model_reset();
      return;
    end
    into_mem = (flush_e || stall_e) ? ins_t'('0) : ex_m;
    for (int i = ML; i > 0; i--) line_m[i] = line_m[i-1];
    line_m[0] = into_mem;
    if (flush_e)       ex_m = '0;
    else if (!stall_e) ex_m = valid_d ? ref_dec(opcode, f3, f7_b6) : ins_t'('0);
  endtask

  task automatic check_all();
    check("ex_valid",  ex_valid,      ex_m.v);
    check("ex_alu",    ex_alu_ctl,    ex_m.alu);
    check("ex_asrc",   ex_alu_src,    ex_m.asrc);
    check("ex_branch", ex_branch,     ex_m.br);
    check("ex_jmp",    ex_jmp,        ex_m.jmp);
    check("ex_jalr",   ex_jalr,       ex_m.jalr);
    check("ex_f3",     ex_f3,         ex_m.f3);
    check("ex_load",   ex_is_load,    ex_m.ld);
    check("ex_ill",    ex_illegal,    ex_m.ill);
    check("mem_valid", mem_valid,     line_m[0].v);
    check("mem_write", mem_write,     line_m[0].mw);
    check("mem_rw",    mem_reg_write, line_m[0].rw);
    check("wb_valid",  wb_valid,      line_m[ML].v);
    check("wb_rw",     wb_reg_write,  line_m[ML].rw);
    check("wb_res",    wb_result_src, line_m[ML].res);
  endtask

  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] fn3,
                      input logic b30, input logic st, input logic fl);
    valid_d = v; opcode = op; f3 = fn3; f7_b6 = b30; stall_e = st; flush_e = fl;
    #1;
    check("imm_src", imm_src, ref_imm(op));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  int mw_cnt;
  logic [6:0] ops [10];

  initial begin
    rst_n = 1'b0; valid_d = 0; opcode = 0; f3 = 0; f7_b6 = 0; stall_e = 0; flush_e = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    idle(2);

    // R-type sub: EX after one edge, WB after 2+ML edges
    step(1'b1, RT, 3'd0, 1'b1, 1'b0, 1'b0);
    check("sub_alu", ex_alu_ctl, 1);
    for (int k = 2; k <= 7; k++) begin
      idle(1);
      check("sub_wb_rw", wb_reg_write, (k == 2 + ML) ? 1 : 0);
    end

    step(1'b1, IT, 3'd5, 1'b1, 1'b0, 1'b0);
    check("srai_alu", ex_alu_ctl, 8);
    check("srai_src", ex_alu_src, 1);
    opcode = LUI;
    #1;
    check("lui_imm", imm_src, 3'b100);
    step(1'b1, LUI, 3'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a load sits in EX
    step(1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_load",  ex_is_load, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    model_reset();
    check_all();
    step(1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Store held in EX across a two-cycle stall
    idle(ML + 2);
    step(1'b1, SW, 3'd2, 1'b0, 1'b0, 1'b0);
    mw_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, RT, 3'd0, 1'b0, 1'b1, 1'b0);
      check("stall_ex_mw", 32'(ex_m.mw & ex_valid), 1);
      mw_cnt += int'(mem_write);
    end
    for (int k = 0; k < ML + 2; k++) begin
      idle(1);
      mw_cnt += int'(mem_write);
    end
    check("sw_mw_once", mw_cnt, 1);

    // Flush and stall together with a branch in ID
    step(1'b1, BR, 3'd1, 1'b0, 1'b1, 1'b1);
    check("flush_branch", ex_branch, 0);
    check("flush_valid", ex_valid, 0);

    step(1'b1, BAD, 3'd3, 1'b1, 1'b0, 1'b0);
    check("illegal_ex", ex_illegal, 1);
    idle(ML + 2);

    ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, BAD, 7'd0};
    for (int n = 0; n < 400; n++) begin
      int unsigned idx = $urandom_range(0, 9);
      logic [6:0] op = (idx == 9) ? 7'($urandom) : ops[idx];
      step(($urandom % 4) != 0, op, 3'($urandom), 1'($urandom),
           ($urandom % 5) == 0, ($urandom % 8) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
